bnn_fc_classifier: RTL and testbench

BNN_FC_CLASSIFIER -- requirements
Module: bnn_fc_classifier

---
 rtl/bnn_fc_classifier_pkg.sv | 23 ++
 rtl/bnn_fc_classifier_popcount.sv | 25 ++
 rtl/bnn_fc_classifier.sv | 112 +++++++++++
 tb/tb_bnn_fc_classifier.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_fc_classifier_pkg.sv
// Shared BNN definitions: convolution-stage widths, FC classifier widths and FC FSM state encoding.
package bnn_fc_classifier_pkg;

    // Convolution stage geometry feeding the concatenator
    localparam int CONV_KS   = 3;
    localparam int CONV_CH   = 1;
    localparam int CONV_MAPS = 2;
    localparam int CONV_OUTW = 77;

    // Fully-connected classifier defaults; feature width is CONV_MAPS * CONV_OUTW
    localparam int IL_DEF = CONV_MAPS * CONV_OUTW;
    localparam int NC_DEF = 10;
    localparam int PL_DEF = 8;
    localparam int CL_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fcState_t;

endpackage

// File: rtl/bnn_fc_classifier_popcount.sv
// Combinational XNOR-popcount: number of agreeing bit positions between two binary vectors.
module bnn_popcount #(
    parameter int IL = 154,
    parameter int PL = 8
) (
    input  logic [IL-1:0] iA,
    input  logic [IL-1:0] iB,
    output logic [PL-1:0] oCount
);

    logic [IL-1:0] agree;
    logic [PL-1:0] count;

    // Linear sum is written for clarity; synthesis rebalances it into an adder tree
    always_comb begin
        agree = ~(iA ^ iB);
        count = '0;
        for (int i = 0; i < IL; i++) begin
            count = count + PL'(agree[i]);
        end
    end

    assign oCount = count;

endmodule

// File: rtl/bnn_fc_classifier.sv
// BNN fully-connected output layer: streams NC weight rows from a synchronous ROM,
// scores each class by XNOR-popcount and reports the argmax (lowest index wins ties).
module bnn_fc_classifier
    import bnn_fc_classifier_pkg::*;
#(
    parameter int IL = IL_DEF,
    parameter int NC = NC_DEF,
    parameter int PL = PL_DEF,
    parameter int CL = CL_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic [IL-1:0] iDATA,
    output logic [CL-1:0] oW_ADDR,
    input  logic [IL-1:0] iWEIGHT,
    output logic [CL-1:0] oCLASS,
    output logic [PL-1:0] oSCORE,
    output logic          oVALID,
    output logic          oBUSY,
    output logic [1:0]    oSTATE
);

    localparam logic [CL-1:0] LAST_CLASS = CL'(NC - 1);

    fcState_t      state;
    logic [CL-1:0] classCnt;
    logic [IL-1:0] featReg;
    logic [PL-1:0] bestScore;
    logic [CL-1:0] bestClass;
    logic          scoreValid;
    logic [CL-1:0] scoreClass;
    logic [PL-1:0] curScore;
    logic [PL-1:0] candScore;
    logic [CL-1:0] candClass;

    bnn_popcount #(
        .IL(IL),
        .PL(PL)
    ) uPopcount (
        .iA    (featReg),
        .iB    (iWEIGHT),
        .oCount(curScore)
    );

    // ROM data lags the address by one cycle, so scoreValid/scoreClass tag the row now on iWEIGHT
    always_comb begin
        candScore = bestScore;
        candClass = bestClass;
        if (scoreValid && ((scoreClass == '0) || (curScore > bestScore))) begin
            candScore = curScore;
            candClass = scoreClass;
        end
    end

    assign oW_ADDR = (state == RUN) ? classCnt : '0;
    assign oSTATE  = state;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= IDLE;
            classCnt   <= '0;
            featReg    <= '0;
            bestScore  <= '0;
            bestClass  <= '0;
            scoreValid <= 1'b0;
            scoreClass <= '0;
            oCLASS     <= '0;
            oSCORE     <= '0;
            oVALID     <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            scoreValid <= (state == RUN);
            scoreClass <= classCnt;
            bestScore  <= candScore;
            bestClass  <= candClass;
            oVALID     <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (iSTART) begin
                        featReg  <= iDATA;
                        classCnt <= '0;
                        oBUSY    <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (classCnt == LAST_CLASS) begin
                        classCnt <= '0;
                        state    <= DRAIN;
                    end else begin
                        classCnt <= classCnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last class is scored this cycle, so publish the candidate, not the held best
                    oCLASS <= candClass;
                    oSCORE <= candScore;
                    oVALID <= 1'b1;
                    oBUSY  <= 1'b0;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_fc_classifier.sv
// Self-checking bench for bnn_fc_classifier: directed scenarios plus random vectors vs. a popcount/argmax model.
module tb_bnn_fc_classifier;

    localparam int IL = 154;
    localparam int NC = 10;
    localparam int PL = 8;
    localparam int CL = 4;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iSTART = 1'b0;
    logic [IL-1:0] iDATA = '0;
    logic [IL-1:0] iWEIGHT = '0;
    logic [CL-1:0] oW_ADDR;
    logic [CL-1:0] oCLASS;
    logic [PL-1:0] oSCORE;
    logic          oVALID;
    logic          oBUSY;
    logic [1:0]    oSTATE;

    logic [IL-1:0] rom [0:15];
    int vectors = 0;
    int fails = 0;

    bnn_fc_classifier #(
        .IL(IL),
        .NC(NC),
        .PL(PL),
        .CL(CL)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iSTART (iSTART),
        .iDATA  (iDATA),
        .oW_ADDR(oW_ADDR),
        .iWEIGHT(iWEIGHT),
        .oCLASS (oCLASS),
        .oSCORE (oSCORE),
        .oVALID (oVALID),
        .oBUSY  (oBUSY),
        .oSTATE (oSTATE)
    );

    always #5 iCLK = ~iCLK;

    // Synchronous weight ROM: row appears one cycle after its address
    always @(posedge iCLK) iWEIGHT <= rom[oW_ADDR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [IL-1:0] randVec();
        logic [159:0] tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return tmp[IL-1:0];
    endfunction

    function automatic logic [IL-1:0] flipMask(input int off, input int n);
        logic [IL-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[(off + i) % IL] = 1'b1;
        return m;
    endfunction

    // Reference: score every class, keep the first strictly larger score
    task automatic modelRun(input logic [IL-1:0] feat, output int cls, output int score);
        int s;
        cls = 0;
        score = -1;
        for (int k = 0; k < NC; k++) begin
            s = $countones(~(feat ^ rom[k]));
            if (s > score) begin
                score = s;
                cls = k;
            end
        end
    endtask

    task automatic startPulse(input logic [IL-1:0] feat);
        @(negedge iCLK);
        iDATA = feat;
        iSTART = 1'b1;
        @(posedge iCLK);
        #1;
    endtask

    // Starts a run, optionally pulses iSTART again before edge injectAt, checks every oVALID seen
    task automatic runAndCheck(input string tag, input logic [IL-1:0] feat, input int injectAt,
                               input logic [IL-1:0] injectData, input int expPulses,
                               output int cls1, output int score1);
        int pulses, lat1, lat2, cls2, score2, expCls, expScore;
        logic busyFirst, busyEnd;
        logic [CL-1:0] addr3;
        pulses = 0; lat1 = -1; lat2 = -1; cls1 = -1; score1 = -1; cls2 = -1; score2 = -1;
        busyFirst = 1'b0; busyEnd = 1'b1; addr3 = '1;
        startPulse(feat);
        for (int n = 1; n <= 24; n++) begin
            @(negedge iCLK);
            if (n == injectAt) begin
                iSTART = 1'b1;
                iDATA = injectData;
            end else begin
                iSTART = 1'b0;
            end
            @(posedge iCLK);
            #1;
            if (n == 1) busyFirst = oBUSY;
            if (n == 3) addr3 = oW_ADDR;
            if (n == 11) busyEnd = oBUSY;
            if (oVALID) begin
                pulses++;
                if (pulses == 1) begin
                    lat1 = n; cls1 = oCLASS; score1 = oSCORE;
                end else if (pulses == 2) begin
                    lat2 = n; cls2 = oCLASS; score2 = oSCORE;
                end
            end
        end
        iSTART = 1'b0;
        check({tag, " pulses"}, pulses, expPulses);
        check({tag, " busy_run"}, 32'(busyFirst), 1);
        check({tag, " addr3"}, 32'(addr3), 3);
        check({tag, " busy_done"}, 32'(busyEnd), 0);
        check({tag, " latency"}, lat1, 11);
        modelRun(feat, expCls, expScore);
        check({tag, " class"}, cls1, expCls);
        check({tag, " score"}, score1, expScore);
        if (expPulses == 2) begin
            check({tag, " latency2"}, lat2, 23);
            modelRun(injectData, expCls, expScore);
            check({tag, " class2"}, cls2, expCls);
            check({tag, " score2"}, score2, expScore);
        end
    endtask

    initial begin
        int c, s, o2, o7;
        logic [IL-1:0] feat, featB, row;

        for (int k = 0; k < 16; k++) rom[k] = '0;

        // Reset state
        repeat (2) @(posedge iCLK);
        #1;
        check("rst class", 32'(oCLASS), 0);
        check("rst score", 32'(oSCORE), 0);
        check("rst valid", 32'(oVALID), 0);
        check("rst busy", 32'(oBUSY), 0);
        check("rst addr", 32'(oW_ADDR), 0);
        @(negedge iCLK);
        iRST = 1'b1;

        // Perfect match on row 3 only
        for (int k = 0; k < NC; k++) rom[k] = '0;
        rom[3] = '1;
        runAndCheck("onehot", '1, 0, '0, 1, c, s);
        check("onehot class_const", c, 3);
        check("onehot score_const", s, IL);

        // All rows identical: tie resolves to class 0
        row = randVec();
        for (int k = 0; k < NC; k++) rom[k] = row;
        runAndCheck("tie", '0, 0, '0, 1, c, s);
        check("tie class_const", c, 0);
        check("tie score_common", s, IL - $countones(row));

        // Rows 2 and 7 share the maximum of 120
        feat = randVec();
        o2 = $urandom_range(0, IL - 1);
        o7 = $urandom_range(0, IL - 1);
        for (int k = 0; k < NC; k++)
            rom[k] = feat ^ flipMask($urandom_range(0, IL - 1), 35 + $urandom_range(0, 40));
        rom[2] = feat ^ flipMask(o2, IL - 120);
        rom[7] = feat ^ flipMask(o7, IL - 120);
        runAndCheck("dualmax", feat, 0, '0, 1, c, s);
        check("dualmax class_const", c, 2);
        check("dualmax score_const", s, 120);

        // Random rows and features
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < NC; k++) rom[k] = randVec();
            runAndCheck($sformatf("rand%0d", t), randVec(), 0, '0, 1, c, s);
        end

        // Start during RUN is ignored
        for (int k = 0; k < NC; k++) rom[k] = randVec();
        feat = randVec();
        featB = randVec();
        runAndCheck("ignore", feat, 4, featB, 1, c, s);

        // Start sampled in DONE chains a second classification
        runAndCheck("chain", feat, 12, featB, 2, c, s);

        // Reset mid-RUN aborts silently
        startPulse(feat);
        for (int n = 1; n <= 5; n++) begin
            @(negedge iCLK);
            iSTART = 1'b0;
            @(posedge iCLK);
        end
        @(negedge iCLK);
        iRST = 1'b0;
        #1;
        check("abort class", 32'(oCLASS), 0);
        check("abort score", 32'(oSCORE), 0);
        check("abort busy", 32'(oBUSY), 0);
        check("abort addr", 32'(oW_ADDR), 0);
        for (int n = 0; n < 3; n++) begin
            @(posedge iCLK);
            #1;
            check("abort valid", 32'(oVALID), 0);
        end
        @(negedge iCLK);
        iRST = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(posedge iCLK);
            #1;
            check("post_abort valid", 32'(oVALID), 0);
        end
        runAndCheck("fresh", featB, 0, '0, 1, c, s);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
